// File: rtl/attention_key_dot_product_pkg.sv
// Shared types and width derivations for the attention key dot-product unit.
// Element, product and result widths all derive from the element precision and vector size.
package attention_key_dot_product_pkg;

    localparam int DEF_PRECISION_0       = 16;
    localparam int DEF_PRECISION_1       = 3;
    localparam int DEF_TENSOR_SIZE_DIM_0 = 32;
    localparam int DEF_PARALLELISM_DIM_0 = 1;

    typedef logic signed [DEF_PRECISION_0-1:0]   elem_t;
    typedef logic signed [2*DEF_PRECISION_0-1:0] prod_t;

    // Full-precision result: product width plus growth for summing every element.
    function automatic int calc_out_width(input int precision, input int tensor_size);
        return 2 * precision + $clog2(tensor_size);
    endfunction

    function automatic int calc_in_depth(input int tensor_size, input int parallelism);
        return tensor_size / parallelism;
    endfunction

    function automatic int calc_cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/attention_key_dot_product_tree.sv
// PAR signed element products reduced by a combinational binary adder tree.
// Leaves beyond PAR are padded with zero so the tree is always a full power of two.
module attention_key_dot_product_tree
    import attention_key_dot_product_pkg::*;
#(
    parameter int PRECISION_0 = DEF_PRECISION_0,
    parameter int PAR         = DEF_PARALLELISM_DIM_0,
    parameter int OUT_WIDTH   = calc_out_width(DEF_PRECISION_0, DEF_TENSOR_SIZE_DIM_0)
) (
    input  logic [PAR-1:0][PRECISION_0-1:0] data_in,
    input  logic [PAR-1:0][PRECISION_0-1:0] weight,
    output logic signed [OUT_WIDTH-1:0]     sum
);

    localparam int PW = 2 * PRECISION_0;
    localparam int NP = 1 << $clog2(PAR);

    logic signed [PW-1:0]        prod [PAR];
    logic signed [OUT_WIDTH-1:0] node [1:2*NP-1];

    // Heap-ordered tree: node i sums children 2i and 2i+1, leaves start at NP.
    always_comb begin
        for (int j = 0; j < PAR; j++) begin
            prod[j] = PW'($signed(data_in[j])) * PW'($signed(weight[j]));
        end
        for (int k = 0; k < NP; k++) begin
            node[NP+k] = '0;
        end
        for (int j = 0; j < PAR; j++) begin
            node[NP+j] = OUT_WIDTH'(prod[j]);
        end
        for (int i = NP - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        sum = node[1];
    end

endmodule

// File: rtl/attention_key_dot_product.sv
// Joins activation and weight beats, accumulates one vector per result and holds
// the result in a single output register with valid/ready backpressure.
module attention_key_dot_product
    import attention_key_dot_product_pkg::*;
#(
    parameter int PRECISION_0       = DEF_PRECISION_0,
    parameter int PRECISION_1       = DEF_PRECISION_1,
    parameter int TENSOR_SIZE_DIM_0 = DEF_TENSOR_SIZE_DIM_0,
    parameter int PARALLELISM_DIM_0 = DEF_PARALLELISM_DIM_0,
    localparam int IN_DEPTH  = calc_in_depth(TENSOR_SIZE_DIM_0, PARALLELISM_DIM_0),
    localparam int OUT_WIDTH = calc_out_width(PRECISION_0, TENSOR_SIZE_DIM_0)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PARALLELISM_DIM_0-1:0][PRECISION_0-1:0] data_in,
    input  logic                                          data_in_valid,
    output logic                                          data_in_ready,
    input  logic [PARALLELISM_DIM_0-1:0][PRECISION_0-1:0] weight,
    input  logic                                          weight_valid,
    output logic                                          weight_ready,
    output logic signed [OUT_WIDTH-1:0]                   data_out,
    output logic                                          data_out_valid,
    input  logic                                          data_out_ready
);

    localparam int CNT_W = calc_cnt_width(IN_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

    if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0 || PRECISION_1 >= PRECISION_0) begin : g_bad_params
        $error("attention_key_dot_product: illegal parameter combination");
    end

    logic [CNT_W-1:0]            beat_cnt;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] beat_sum;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic                        first_beat;
    logic                        last_beat;
    logic                        can_accept;
    logic                        fire;

    attention_key_dot_product_tree #(
        .PRECISION_0 (PRECISION_0),
        .PAR         (PARALLELISM_DIM_0),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_tree (
        .data_in (data_in),
        .weight  (weight),
        .sum     (beat_sum)
    );

    // Only the last beat of a vector needs the output register free; earlier beats
    // keep accumulating the next vector while a result waits downstream.
    assign first_beat    = (beat_cnt == '0);
    assign last_beat     = (beat_cnt == LAST_BEAT);
    assign can_accept    = !last_beat || !data_out_valid || data_out_ready;
    assign fire          = data_in_valid && weight_valid && can_accept;
    assign data_in_ready = weight_valid && can_accept;
    assign weight_ready  = data_in_valid && can_accept;
    assign acc_next      = first_beat ? beat_sum : acc + beat_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (fire) begin
                acc      <= acc_next;
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
            if (fire && last_beat) begin
                data_out       <= acc_next;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_attention_key_dot_product.sv
// Directed-plus-random bench for attention_key_dot_product with a sum-of-products
// reference model and an in-order expected-result queue.
module tb_attention_key_dot_product;
    import attention_key_dot_product_pkg::*;

    localparam int P     = 16;
    localparam int F     = 3;
    localparam int N     = 32;
    localparam int PAR   = 4;
    localparam int DEPTH = N / PAR;
    localparam int OW    = 2 * P + $clog2(N);

    typedef logic [PAR-1:0][P-1:0] beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    beat_t                data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    beat_t                weight;
    logic                 weight_valid;
    logic                 weight_ready;
    logic signed [OW-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    always #5 clk = ~clk;

    attention_key_dot_product #(
        .PRECISION_0       (P),
        .PRECISION_1       (F),
        .TENSOR_SIZE_DIM_0 (N),
        .PARALLELISM_DIM_0 (PAR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .weight         (weight),
        .weight_valid   (weight_valid),
        .weight_ready   (weight_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    logic [OW-1:0] exp_q[$];
    beat_t         act_q[$];
    beat_t         wgt_q[$];
    int            checks = 0;
    int            errors = 0;
    int            di_fires = 0;
    int            w_fires = 0;
    bit            prev_hold = 1'b0;
    logic [OW-1:0] prev_out;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the dot product is just the sum of element products.
    task automatic add_vector(input elem_t a[N], input elem_t w[N], input bit push);
        longint s;
        beat_t  ba;
        beat_t  bw;
        s = 0;
        for (int b = 0; b < DEPTH; b++) begin
            for (int j = 0; j < PAR; j++) begin
                ba[j] = a[b*PAR+j];
                bw[j] = w[b*PAR+j];
            end
            act_q.push_back(ba);
            wgt_q.push_back(bw);
        end
        for (int i = 0; i < N; i++) s += longint'(a[i]) * longint'(w[i]);
        if (push) exp_q.push_back(s[OW-1:0]);
    endtask

    task automatic add_random_vector(input bit push);
        elem_t a[N];
        elem_t w[N];
        for (int i = 0; i < N; i++) begin
            a[i] = elem_t'($urandom);
            w[i] = elem_t'($urandom);
        end
        add_vector(a, w, push);
    endtask

    task automatic run_beats(input int n, input int a_pct, input int w_pct, input int r_pct);
        int done;
        int cyc;
        done = 0;
        cyc = 0;
        while (done < n && cyc < 3000) begin
            @(posedge clk);
            #1;
            data_out_ready = ($urandom_range(99) < r_pct);
            data_in        = act_q[0];
            weight         = wgt_q[0];
            data_in_valid  = ($urandom_range(99) < a_pct);
            weight_valid   = ($urandom_range(99) < w_pct);
            @(negedge clk);
            if (data_in_valid && data_in_ready && weight_valid && weight_ready) begin
                void'(act_q.pop_front());
                void'(wgt_q.pop_front());
                done++;
            end
            cyc++;
        end
        if (done < n) check("beat_timeout", done, n);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        data_in_valid  = 1'b0;
        weight_valid   = 1'b0;
        data_out_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: in-order result scoreboard, join rule and hold-under-backpressure.
    always @(negedge clk) begin
        bit di_f;
        bit w_f;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", data_out_valid, 1);
                check("hold_data", data_out, prev_out);
            end
            di_f = data_in_valid && data_in_ready;
            w_f  = weight_valid && weight_ready;
            if (di_f || w_f) check("join", w_f, di_f);
            if (di_f) di_fires++;
            if (w_f) w_fires++;
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", data_out_valid, 0);
                else check("result", data_out, exp_q.pop_front());
            end
            prev_hold = data_out_valid && !data_out_ready;
            prev_out  = data_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        elem_t         va[N];
        elem_t         vw[N];
        logic [OW-1:0] e;

        rst            = 1'b1;
        data_in        = '0;
        weight         = '0;
        data_in_valid  = 1'b0;
        weight_valid   = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_in_ready_idle", data_in_ready, 0);
        weight_valid = 1'b1;
        #1;
        check("in_ready_follows_wvalid", data_in_ready, 1);
        check("w_ready_no_self_dep", weight_ready, 0);
        @(posedge clk);
        #1;
        weight_valid = 1'b0;

        // All ones (1.0 = 0x0008): 32 * 64 = 2048 with 6 fractional bits.
        for (int i = 0; i < N; i++) begin va[i] = 16'sh0008; vw[i] = 16'sh0008; end
        add_vector(va, vw, 1'b1);
        run_beats(DEPTH, 100, 100, 100);
        @(negedge clk);
        check("ones_valid_latency", data_out_valid, 1);
        check("ones_value", data_out, 37'd2048);
        drain();

        // Ramp 1..32 times -1.0: -528 << 6.
        for (int i = 0; i < N; i++) begin va[i] = elem_t'((i + 1) * 8); vw[i] = -16'sh0008; end
        add_vector(va, vw, 1'b1);
        run_beats(DEPTH, 100, 100, 100);
        @(negedge clk);
        e = -33792;
        check("ramp_value", data_out, e);
        drain();

        // Most negative element squared, 32 times: exactly 2^35.
        for (int i = 0; i < N; i++) begin va[i] = 16'sh8000; vw[i] = 16'sh8000; end
        add_vector(va, vw, 1'b1);
        run_beats(DEPTH, 100, 100, 100);
        @(negedge clk);
        check("extreme_value", data_out, 37'h8_0000_0000);
        drain();

        // Backpressure across two vectors: second stalls on its last beat.
        add_random_vector(1'b1);
        add_random_vector(1'b1);
        run_beats(2 * DEPTH - 1, 100, 100, 0);
        @(posedge clk);
        #1;
        data_in        = act_q[0];
        weight         = wgt_q[0];
        data_in_valid  = 1'b1;
        weight_valid   = 1'b1;
        data_out_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("bp_w_ready_low", weight_ready, 0);
            check("bp_in_ready_low", data_in_ready, 0);
            check("bp_first_held", data_out, exp_q[0]);
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        run_beats(1, 100, 100, 100);
        drain();

        // Random data with random gaps and random downstream readiness.
        for (int v = 0; v < 6; v++) add_random_vector(1'b1);
        run_beats(6 * DEPTH, 70, 70, 60);
        drain();

        // Free-running weight source: weight pulses must match activation beats.
        di_fires = 0;
        w_fires  = 0;
        for (int v = 0; v < 3; v++) add_random_vector(1'b1);
        run_beats(3 * DEPTH, 30, 100, 100);
        drain();
        check("w_pulses_eq_beats", w_fires, di_fires);
        check("beats_consumed", di_fires, 3 * DEPTH);

        // Reset mid-vector: partial accumulation must vanish.
        add_random_vector(1'b0);
        run_beats(4, 100, 100, 100);
        rst           = 1'b1;
        data_in       = act_q[0];
        weight        = wgt_q[0];
        data_in_valid = 1'b1;
        weight_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_valid", data_out_valid, 0);
        check("mid_rst_in_ready", data_in_ready, 1);
        rst           = 1'b0;
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        act_q.delete();
        wgt_q.delete();
        add_random_vector(1'b1);
        run_beats(DEPTH, 100, 100, 100);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
